// File: rtl/bcd_digit_scanner_if.sv
// Value handshake between a producer and bcd_digit_scanner.
interface bcd_digit_scanner_if #(
  parameter int unsigned IN_W = 14
);
  logic            in_valid;
  logic            in_ready;
  logic [IN_W-1:0] in_value;

  modport master (output in_valid, output in_value, input in_ready);
  modport slave  (input in_valid, input in_value, output in_ready);
endinterface

// File: rtl/bcd_digit_scanner.sv
// Binary-to-BCD (sequential double-dabble) converter feeding a multiplexed digit scanner.
// Optional leading-zero blanking: define LEADING_ZERO_BLANK_EN.
module bcd_digit_scanner #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned IN_W        = 14,
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bcd_digit_scanner_if.slave    in_if,
  output logic [7:0]            num,
  output logic [DIGITS-1:0]     an,
  output logic                  ovf
);

  // Decimal digits needed to hold 2^w-1.
  function automatic int unsigned f_dec_digits(input int unsigned w);
    longint unsigned v;
    int unsigned     n;
    v = (64'd1 << w) - 64'd1;
    n = 1;
    for (int i = 0; i < 20; i++) begin
      if (v >= 64'd10) begin
        v = v / 64'd10;
        n = n + 1;
      end
    end
    return n;
  endfunction

  localparam int unsigned NIB    = (f_dec_digits(IN_W) > DIGITS) ? f_dec_digits(IN_W) : DIGITS;
  localparam int unsigned BCD_W  = 4 * NIB;
  localparam int unsigned DISP_W = 4 * DIGITS;
  localparam int unsigned CNT_W  = $clog2(IN_W);
  localparam int unsigned REF_W  = $clog2(REFRESH_DIV);
  localparam int unsigned SCAN_W = $clog2(DIGITS);

  typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_LOAD} state_t;

  state_t              r_state, w_state_nxt;
  logic                r_in_ready, w_in_ready_nxt;
  logic                w_accept, w_shift, w_load;
  logic [IN_W-1:0]     r_bin;
  logic [BCD_W-1:0]    r_bcd, w_bcd_adj;
  logic [CNT_W-1:0]    r_cnt;
  logic [DISP_W-1:0]   r_disp, w_disp_nxt;
  logic                r_ovf, w_ovf_nxt;
  logic [REF_W-1:0]    r_ref;
  logic [SCAN_W-1:0]   r_scan;
  logic                w_wrap;
  logic [3:0]          w_digit;
  logic                w_blank_cur;
  logic [7:0]          r_num;
  logic [DIGITS-1:0]   r_an;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= w_in_ready_nxt;
    end
  end

  // Next-state and control strobes
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_shift     = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_if.in_valid && r_in_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = S_CONVERT;
        end
      end
      S_CONVERT: begin
        w_shift = 1'b1;
        if (r_cnt == CNT_W'(IN_W - 1)) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        w_load      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_in_ready_nxt = (w_state_nxt == S_IDLE);
  end

  // Add-3 correction applied before each shift
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int n = 0; n < int'(NIB); n++) begin
      if (r_bcd[4*n +: 4] >= 4'd5) w_bcd_adj[4*n +: 4] = r_bcd[4*n +: 4] + 4'd3;
    end
  end

  // Overflow is judged on the full accumulator, before truncation to the display width
  always_comb begin
    w_ovf_nxt  = |(r_bcd >> DISP_W);
    w_disp_nxt = w_ovf_nxt ? {DIGITS{4'h9}} : r_bcd[DISP_W-1:0];
  end

  // Conversion datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin <= '0;
      r_bcd <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_bin <= in_if.in_value;
      r_bcd <= '0;
      r_cnt <= '0;
    end else if (w_shift) begin
      r_bcd <= {w_bcd_adj[BCD_W-2:0], r_bin[IN_W-1]};
      r_bin <= {r_bin[IN_W-2:0], 1'b0};
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Display register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_disp <= '0;
      r_ovf  <= 1'b0;
    end else if (w_load) begin
      r_disp <= w_disp_nxt;
      r_ovf  <= w_ovf_nxt;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] r_blank, w_blank_nxt;
  logic              w_seen_nz;

  // Digits above the most-significant nonzero digit go dark; digit 0 always shows
  always_comb begin
    w_blank_nxt = '0;
    w_seen_nz   = 1'b0;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      w_seen_nz      = w_seen_nz | (w_disp_nxt[4*i +: 4] != 4'h0);
      w_blank_nxt[i] = ~w_seen_nz;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_blank <= '0;
    else if (w_load) r_blank <= w_blank_nxt;
  end

  assign w_blank_cur = r_blank[r_scan];
`else
  assign w_blank_cur = 1'b0;
`endif

  // Refresh timer and scan index, free-running
  assign w_wrap = (r_ref == REF_W'(REFRESH_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ref  <= '0;
      r_scan <= '0;
    end else begin
      r_ref <= w_wrap ? '0 : r_ref + REF_W'(1);
      if (w_wrap) r_scan <= (r_scan == SCAN_W'(DIGITS - 1)) ? '0 : r_scan + SCAN_W'(1);
    end
  end

  assign w_digit = r_disp[{r_scan, 2'b00} +: 4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_num <= 8'h00;
      r_an  <= ~DIGITS'(1);
    end else if (w_blank_cur) begin
      r_num <= 8'h00;
      r_an  <= '1;
    end else begin
      r_num <= {4'h0, w_digit};
      r_an  <= ~(DIGITS'(1) << r_scan);
    end
  end

  assign in_if.in_ready = r_in_ready;
  assign num            = r_num;
  assign an             = r_an;
  assign ovf            = r_ovf;

endmodule
